// File: rtl/mips_defs_pkg.sv
// Shared MIPS definitions: mul/div op encodings, muldiv FSM states, default width.
package mips_defs;

    localparam int DEFAULT_WIDTH = 32;

    // Encoding of the 3-bit op field driven by the controller
    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_t;

    // Iterative multiply/divide sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath.
// Multiply: shift-add on a 2*WIDTH-bit {partial product, multiplier} register.
// Divide: restoring step; acc[WIDTH-1:0] shifts the dividend out at the top
// and the quotient bits in at the bottom, rem holds the partial remainder.
import mips_defs::*;

module muldiv_step #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 div_mode,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     rem,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_next,
    output logic [WIDTH-1:0]     rem_next,
    output logic                 qbit
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // Single iteration: add-and-shift for multiply, trial subtract for divide
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        shifted  = {rem, acc[WIDTH-1]};
        diff     = shifted[WIDTH-1:0] - operand;
        qbit     = 1'b0;
        acc_next = acc;
        rem_next = rem;
        if (div_mode) begin
            // The shifted remainder is WIDTH+1 bits wide, so compare before
            // truncating; when it fits, the difference always fits in WIDTH.
            qbit     = (shifted >= {1'b0, operand});
            rem_next = qbit ? diff : shifted[WIDTH-1:0];
            acc_next = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], qbit};
        end else begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// MIPS HI/LO multiply/divide unit. MULT/MULTU/DIV/DIVU iterate over WIDTH
// cycles plus one sign-fix cycle; MTHI/MTLO write HI/LO directly from IDLE.
import mips_defs::*;

module muldiv_unit #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic               accept, step, fix, mt_hi, mt_lo;

    // Operation context captured when a mul/div is accepted
    logic               div_r;
    logic               neg_a, neg_b;
    logic               div_zero;
    logic [WIDTH-1:0]   raw_a;
    logic [WIDTH-1:0]   operand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;

    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   rem_next;
    logic               qbit;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rmd;
    logic [WIDTH-1:0]   res_hi, res_lo;

    logic               signed_op;

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    assign signed_op = ~op[0];

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_mode (div_r),
        .acc      (acc),
        .rem      (rem),
        .operand  (operand),
        .acc_next (acc_next),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    // Next-state and control decode; start is only honoured in IDLE
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        accept     = 1'b0;
        step       = 1'b0;
        fix        = 1'b0;
        mt_hi      = 1'b0;
        mt_lo      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            accept     = 1'b1;
                            state_next = S_RUN;
                        end
                        OP_MTHI: mt_hi = 1'b1;
                        OP_MTLO: mt_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == LAST) state_next = S_FIX;
            end
            S_FIX: begin
                busy       = 1'b1;
                fix        = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Architectural state and control: FSM, iteration counter, done, HI/LO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_next;
            done  <= fix;
            if (accept)
                cnt <= '0;
            else if (step)
                cnt <= cnt + ONE;
            if (fix) begin
                hi <= res_hi;
                lo <= res_lo;
            end else begin
                if (mt_hi) hi <= srca;
                if (mt_lo) lo <= srca;
            end
        end
    end

    // Iteration datapath: load magnitudes on accept, advance one step per RUN cycle
    always_ff @(posedge clk) begin
        if (accept) begin
            div_r    <= op[1];
            neg_a    <= signed_op & srca[WIDTH-1];
            neg_b    <= signed_op & srcb[WIDTH-1];
            div_zero <= (srcb == '0);
            raw_a    <= srca;
            operand  <= signed_op ? abs_val(srcb) : srcb;
            acc      <= {{WIDTH{1'b0}}, (signed_op ? abs_val(srca) : srca)};
            rem      <= '0;
        end else if (step) begin
            acc <= acc_next;
            rem <= rem_next;
        end
    end

    // Sign correction and result selection written to HI/LO in FIX
    always_comb begin
        prod = (neg_a ^ neg_b) ? -acc : acc;
        quo  = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rmd  = neg_a ? -rem : rem;
        if (!div_r) begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else if (div_zero) begin
            res_hi = raw_a;
            res_lo = '1;
        end else begin
            res_hi = rmd;
            res_lo = quo;
        end
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core. It sits directly downstream of the register file and consumes the two read-port operands (rs on srca, rt on srcb). It executes MULT/MULTU/DIV/DIVU over WIDTH+1 cycles and MTHI/MTLO in one cycle. It exposes hi/lo for MFHI/MFLO and asserts busy so the controller can stall.

Parameters:
WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  issue request; sampled on the rising edge
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved
srca  input  WIDTH  rs operand from regfile rd1
srcb  input  WIDTH  rt operand from regfile rd2
busy  output  1  high while a multiply/divide is in flight
done  output  1  one-cycle pulse on the cycle hi/lo first show a new mul/div result
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- One clock (clk). Asynchronous active-high reset. Reset forces: state IDLE, busy=0, done=0, hi=0, lo=0, internal counter=0.
- FSM states:
  - IDLE: busy=0; start accepted.
  - RUN: busy=1; one step per cycle for exactly WIDTH cycles.
  - FIX: busy=1; sign correction, then HI/LO write.
- IDLE + start + mul/div op (edge E0): latch |srca| and |srcb| (signed ops only; unsigned ops take the raw values), latch the sign flags, counter=0, go to RUN.
- RUN: each edge performs one step and increments the counter.
  - Multiply: shift-add, one bit per cycle, 2*WIDTH-bit product.
  - Divide: restoring, one quotient bit per cycle, (WIDTH+1)-bit partial remainder.
  - After edge E0+WIDTH, go to FIX.
- FIX (edge E0+WIDTH+1): write hi/lo, go to IDLE; done=1 for exactly that following cycle.
  - Total latency is WIDTH+1 cycles from the accepting edge to a valid hi/lo (33 at WIDTH=32).
  - busy is high for exactly WIDTH+1 cycles.
- hi/lo keep their old values throughout RUN/FIX. Only the FIX edge, MTHI or MTLO changes them.
- Multiply: {hi,lo} = product. MULT negates the 2*WIDTH-bit product when the operand signs differ.
- Divide: lo = quotient, hi = remainder.
  - DIV negates the quotient when the signs differ; the remainder takes the sign of the dividend.
  - Most-negative / -1: lo=0x80000000, hi=0 at WIDTH=32. No trap.
- Divide by zero (srcb==0) runs the full latency, then lo = all ones and hi = srca (raw, no sign fix). No exception.
- MTHI/MTLO in IDLE with start: hi<=srca (MTHI) or lo<=srca (MTLO) on the same edge. busy and done stay 0.
- start while busy=1 is ignored: no operand capture, no hi/lo change. The controller must stall; the unit does not queue.
- Reserved op with start in IDLE: no effect.
- Reset during RUN/FIX aborts the operation immediately. hi/lo return to 0; done is not pulsed.

Decomposition:
- Shared package mips_defs holds:
  - the op encodings (OP_MULT..OP_MTLO);
  - the FSM state encoding (S_IDLE, S_RUN, S_FIX);
  - default WIDTH.
- One natural sub-module, muldiv_step: the combinational single-iteration datapath. Given mode, accumulator/remainder and operand, it returns the next accumulator/remainder and the quotient bit.
- FSM, counter, sign handling and HI/LO registers live in muldiv_unit.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF:
  - busy is high for 33 cycles and done pulses once;
  - then hi=0xFFFFFFFE, lo=0x00000001.
- MULT -3 (0xFFFFFFFD) x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=0x00000064 after 33 cycles.
- Interaction case:
  - MTHI 0x12345678, then MULTU 6 x 7;
  - assert start with MTLO 0xAA during busy: ignored, and hi stays 0x12345678 until FIX;
  - final result hi=0, lo=42;
  - a second MULTU with reset at cycle 10 -> busy=0, hi=lo=0, no done pulse.
